serial_adder_subtractor: RTL and testbench
==========================================

Name: serial_adder_subtractor

Overview:
- Bit-serial N-bit adder/subtractor. Sums (a+b) or differences (a-b) one bit per clock through a single full-adder/full-subtractor cell and a carry/borrow flip-flop.
- It is the addition direction paired with the team's full-subtractor logic, sequenced by a small FSM with a start/busy/done handshake.
- Sits beside the combinational adder/subtractor blocks. Used where area matters more than latency.

Parameters:
- WIDTH, 8, operand and result width in bits (>=2).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request; sampled only when the FSM is IDLE or DONE.
- a  input  WIDTH  minuend/augend, unsigned or two's complement; captured on accepted start.
- b  input  WIDTH  subtrahend/addend; captured on accepted start.
- sub  input  1  0 = add, 1 = subtract; captured on accepted start.
- busy  output  1  high while bits are being processed.
- done  output  1  one-cycle pulse when result, cout and ovf are valid.
- result  output  WIDTH  a+b or a-b, modulo 2^WIDTH.
- cout  output  1  add mode: carry out. Sub mode: borrow out (1 iff a<b unsigned).
- ovf  output  1  two's-complement signed overflow.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is asynchronous and active-high.
- Reset values: state=IDLE, busy=0, done=0, result=0, cout=0, ovf=0. Bit counter, operand shift registers and carry/borrow flop are all 0.
- FSM states: IDLE, SHIFT, DONE.
- IDLE: start=1 at an edge is accepted. On that edge:
  - latch a, b, sub into shift registers;
  - clear the carry/borrow flop to 0;
  - clear the counter;
  - go to SHIFT, busy=1.
- SHIFT: each edge processes the operand LSBs through the cell.
  - Add: s = ai^bi^c; c' = ai&bi | c&(ai^bi).
  - Sub: d = ai^bi^w; w' = ~ai&bi | ~(ai^bi)&w.
  - The result bit shifts into the MSB of an internal shift register. Operands shift right. Counter increments.
- Last SHIFT edge (counter==WIDTH-1):
  - load result from the completed shift register, cout from c'/w', ovf from the latched operand MSBs and the result MSB;
  - go to DONE, busy=0, done=1.
- Overflow rule: add: a[MSB]==b[MSB] && result[MSB]!=a[MSB]. Sub: a[MSB]!=b[MSB] && result[MSB]!=a[MSB].
- DONE: lasts exactly one cycle, then IDLE. done=0 except in DONE.
  - start=1 in DONE is accepted exactly as in IDLE, giving back-to-back operation with no gap cycle.
- Latency: busy rises on the accepting edge. Exactly WIDTH edges later, busy falls and done rises in the same cycle.
- Holding: result/cout/ovf change only on the final SHIFT edge. They hold their value through IDLE and through the whole next operation until its own final edge. Intermediate bits never appear on result.
- start during SHIFT: ignored; operands and mode are not re-sampled.
- Changes on a/b/sub after acceptance have no effect.
- Reset mid-operation: immediate abort. All outputs return to reset values; no done pulse.

Decomposition:
- Shared package serial_arith_pkg:
  - FSM state enum (IDLE, SHIFT, DONE);
  - localparam CNT_W = $clog2(WIDTH) helper;
  - mode constants MODE_ADD=0, MODE_SUB=1.
- One combinational sub-module, add_sub_cell. Inputs ai, bi, cin, sub. Outputs y, cy (carry or borrow per the equations above).
- Top holds the FSM, counter, shift registers and flops.

Test Plan:
- WIDTH=8, add 0x2D+0x16 -> result=0x43, cout=0, ovf=0. done exactly 8 edges after accepting edge, high 1 cycle. busy high for those 8 cycles.
- Sub 0x05-0x07 -> result=0xFE, cout(borrow)=1, ovf=0. Sub 0x80-0x01 -> result=0x7F, cout=0, ovf=1.
- Add 0x7F+0x01 -> 0x80, cout=0, ovf=1. Add 0xFF+0x01 -> 0x00, cout=1, ovf=0.
- Back-to-back and ignored start:
  - start held high through SHIFT with different a/b -> first result unaffected;
  - start in DONE -> second op begins with no idle cycle;
  - result holds 0x43 until the second op's final edge.
- Reset mid-op: assert rst after 3 SHIFT cycles -> busy=0, result=0, cout=0, ovf=0 immediately; no done pulse. The next start completes correctly.
- WIDTH=4 exhaustive: all 256 (a,b) pairs x both modes compared against a±b mod 16, the carry/borrow out, and the signed overflow rule.

Source files
------------

// File: rtl/serial_arith_pkg.sv
// Shared types and constants for the bit-serial adder/subtractor.
package serial_arith_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic MODE_ADD = 1'b0;
  localparam logic MODE_SUB = 1'b1;

  // Bit-counter width for a given operand width; never narrower than one bit.
  function automatic int cnt_w(input int width);
    return (width > 1) ? $clog2(width) : 1;
  endfunction

endpackage

// File: rtl/add_sub_cell.sv
// One-bit full-adder / full-subtractor cell; cy is carry (add) or borrow (sub).
module add_sub_cell
  import serial_arith_pkg::*;
(
  input  logic ai,
  input  logic bi,
  input  logic cin,
  input  logic sub,
  output logic y,
  output logic cy
);

  logic w_x;

  assign w_x = ai ^ bi;
  assign y   = w_x ^ cin;
  assign cy  = (sub == MODE_SUB) ? ((~ai & bi) | (~w_x & cin))
                                 : ((ai & bi) | (w_x & cin));

endmodule

// File: rtl/serial_adder_subtractor.sv
// Bit-serial WIDTH-bit adder/subtractor: one bit per clock through a single
// add_sub_cell, sequenced by an IDLE/SHIFT/DONE handshake FSM.
module serial_adder_subtractor
  import serial_arith_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             ovf
);

  localparam int                CNT_W = cnt_w(WIDTH);
  localparam logic [CNT_W-1:0]  LAST  = CNT_W'(WIDTH - 1);

  state_t             r_state;
  state_t             w_state_nxt;
  logic [CNT_W-1:0]   r_cnt;
  logic [WIDTH-1:0]   r_a;
  logic [WIDTH-1:0]   r_b;
  logic [WIDTH-1:0]   r_acc;
  logic [WIDTH-1:0]   r_result;
  logic               r_sub;
  logic               r_c;
  logic               r_cout;
  logic               r_ovf;
  logic               r_a_msb;
  logic               r_b_msb;

  logic               w_y;
  logic               w_cy;
  logic               w_accept;
  logic               w_last;
  logic               w_ovf;
  logic [WIDTH-1:0]   w_acc_nxt;

  add_sub_cell u_cell (
    .ai  (r_a[0]),
    .bi  (r_b[0]),
    .cin (r_c),
    .sub (r_sub),
    .y   (w_y),
    .cy  (w_cy)
  );

  assign w_accept  = start && ((r_state == IDLE) || (r_state == DONE));
  assign w_last    = (r_state == SHIFT) && (r_cnt == LAST);
  assign w_acc_nxt = {w_y, r_acc[WIDTH-1:1]};
  // Overflow uses the MSBs captured at start, since r_a/r_b have shifted away.
  assign w_ovf     = (r_sub == MODE_SUB)
                   ? ((r_a_msb != r_b_msb) && (w_y != r_a_msb))
                   : ((r_a_msb == r_b_msb) && (w_y != r_a_msb));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (start) w_state_nxt = SHIFT;
      SHIFT:   if (r_cnt == LAST) w_state_nxt = DONE;
      DONE:    w_state_nxt = start ? SHIFT : IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt    <= '0;
      r_a      <= '0;
      r_b      <= '0;
      r_acc    <= '0;
      r_sub    <= 1'b0;
      r_c      <= 1'b0;
      r_a_msb  <= 1'b0;
      r_b_msb  <= 1'b0;
      r_result <= '0;
      r_cout   <= 1'b0;
      r_ovf    <= 1'b0;
    end else if (w_accept) begin
      r_cnt    <= '0;
      r_a      <= a;
      r_b      <= b;
      r_sub    <= sub;
      r_c      <= 1'b0;
      r_a_msb  <= a[WIDTH-1];
      r_b_msb  <= b[WIDTH-1];
    end else if (r_state == SHIFT) begin
      r_cnt    <= r_cnt + 1'b1;
      r_a      <= r_a >> 1;
      r_b      <= r_b >> 1;
      r_acc    <= w_acc_nxt;
      r_c      <= w_cy;
      if (w_last) begin
        r_result <= w_acc_nxt;
        r_cout   <= w_cy;
        r_ovf    <= w_ovf;
      end
    end
  end

  assign busy   = (r_state == SHIFT);
  assign done   = (r_state == DONE);
  assign result = r_result;
  assign cout   = r_cout;
  assign ovf    = r_ovf;

endmodule

// File: tb/tb_serial_adder_subtractor.sv
// Self-checking bench: directed corner cases, random ops (WIDTH=8) and an
// exhaustive sweep (WIDTH=4) against an arithmetic reference model.
module tb_serial_adder_subtractor;

  logic       clk = 1'b0;
  logic       rst = 1'b1;

  logic       start8 = 1'b0, sub8 = 1'b0;
  logic [7:0] a8 = '0, b8 = '0;
  logic       busy8, done8, cout8, ovf8;
  logic [7:0] res8;

  logic       start4 = 1'b0, sub4 = 1'b0;
  logic [3:0] a4 = '0, b4 = '0;
  logic       busy4, done4, cout4, ovf4;
  logic [3:0] res4;

  int checks = 0;
  int errors = 0;
  int prev_res8 = 0;
  int prev_cout8 = 0;
  int prev_ovf8 = 0;

  always #5 clk = ~clk;

  serial_adder_subtractor #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8), .sub(sub8),
    .busy(busy8), .done(done8), .result(res8), .cout(cout8), .ovf(ovf8)
  );

  serial_adder_subtractor #(.WIDTH(4)) dut4 (
    .clk(clk), .rst(rst), .start(start4), .a(a4), .b(b4), .sub(sub4),
    .busy(busy4), .done(done4), .result(res4), .cout(cout4), .ovf(ovf4)
  );

  // Reference: plain integer arithmetic on unsigned and signed interpretations.
  function automatic void ref_calc(input int w, input int a, input int b, input bit s,
                                   output int r, output int c, output int v);
    int m, sa, sb, sr;
    m  = 1 << w;
    sa = (a >= m / 2) ? a - m : a;
    sb = (b >= m / 2) ? b - m : b;
    if (!s) begin
      r  = (a + b) % m;
      c  = (a + b >= m) ? 1 : 0;
      sr = sa + sb;
    end else begin
      r  = (a - b + m) % m;
      c  = (a < b) ? 1 : 0;
      sr = sa - sb;
    end
    v = (sr < -(m / 2) || sr >= m / 2) ? 1 : 0;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One 8-bit op from IDLE: checks latency, busy window, result holding and done pulse.
  task automatic do_op8(input int a, input int b, input bit s);
    int r, c, v;
    ref_calc(8, a, b, s, r, c, v);
    @(negedge clk);
    a8 = 8'(a); b8 = 8'(b); sub8 = s; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    chk("busy_rise", {31'b0, busy8}, 1);
    for (int k = 1; k < 8; k++) begin
      @(posedge clk); #1;
      chk("busy_hold", {31'b0, busy8}, 1);
      chk("done_early", {31'b0, done8}, 0);
      chk("result_hold", {24'b0, res8}, prev_res8);
    end
    @(posedge clk); #1;
    chk("busy_fall", {31'b0, busy8}, 0);
    chk("done_rise", {31'b0, done8}, 1);
    chk("result", {24'b0, res8}, r);
    chk("cout", {31'b0, cout8}, c);
    chk("ovf", {31'b0, ovf8}, v);
    prev_res8 = r; prev_cout8 = c; prev_ovf8 = v;
    @(posedge clk); #1;
    chk("done_pulse", {31'b0, done8}, 0);
    chk("result_after", {24'b0, res8}, prev_res8);
  endtask

  task automatic do_op4(input int a, input int b, input bit s);
    int r, c, v;
    ref_calc(4, a, b, s, r, c, v);
    @(negedge clk);
    a4 = 4'(a); b4 = 4'(b); sub4 = s; start4 = 1'b1;
    @(posedge clk); #1;
    start4 = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("w4_done", {31'b0, done4}, 1);
    chk("w4_result", {28'b0, res4}, r);
    chk("w4_cout", {31'b0, cout4}, c);
    chk("w4_ovf", {31'b0, ovf4}, v);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int ra, rb, r, c, v;
    bit rs, seen_done;

    #12;
    chk("rst_busy", {31'b0, busy8}, 0);
    chk("rst_done", {31'b0, done8}, 0);
    chk("rst_result", {24'b0, res8}, 0);
    chk("rst_cout", {31'b0, cout8}, 0);
    chk("rst_ovf", {31'b0, ovf8}, 0);
    @(negedge clk);
    rst = 1'b0;

    do_op8(8'h2D, 8'h16, 1'b0);
    chk("add_2d_16", {24'b0, res8}, 32'h43);
    do_op8(8'h05, 8'h07, 1'b1);
    do_op8(8'h80, 8'h01, 1'b1);
    do_op8(8'h7F, 8'h01, 1'b0);
    do_op8(8'hFF, 8'h01, 1'b0);
    chk("wrap_cout", {31'b0, cout8}, 1);

    // start held through SHIFT with changing operands, then back-to-back from DONE
    @(negedge clk);
    a8 = 8'h2D; b8 = 8'h16; sub8 = 1'b0; start8 = 1'b1;
    @(posedge clk); #1;
    ra = int'($urandom_range(255)); rb = int'($urandom_range(255)); rs = 1'($urandom_range(1));
    a8 = 8'(ra); b8 = 8'(rb); sub8 = rs;
    for (int k = 1; k < 8; k++) begin
      @(posedge clk); #1;
      chk("ign_busy", {31'b0, busy8}, 1);
    end
    @(posedge clk); #1;
    chk("ign_done", {31'b0, done8}, 1);
    chk("ign_result", {24'b0, res8}, 32'h43);
    chk("ign_cout", {31'b0, cout8}, 0);
    chk("ign_ovf", {31'b0, ovf8}, 0);
    @(posedge clk); #1;
    start8 = 1'b0;
    chk("b2b_no_gap", {31'b0, busy8}, 1);
    chk("b2b_done_low", {31'b0, done8}, 0);
    for (int k = 1; k < 8; k++) begin
      @(posedge clk); #1;
      chk("b2b_hold", {24'b0, res8}, 32'h43);
    end
    @(posedge clk); #1;
    ref_calc(8, ra, rb, rs, r, c, v);
    chk("b2b_done", {31'b0, done8}, 1);
    chk("b2b_result", {24'b0, res8}, r);
    chk("b2b_cout", {31'b0, cout8}, c);
    chk("b2b_ovf", {31'b0, ovf8}, v);
    prev_res8 = r;
    @(posedge clk); #1;

    // reset in the middle of an operation
    @(negedge clk);
    a8 = 8'h7F; b8 = 8'h01; sub8 = 1'b0; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("abort_busy", {31'b0, busy8}, 0);
    chk("abort_done", {31'b0, done8}, 0);
    chk("abort_result", {24'b0, res8}, 0);
    chk("abort_cout", {31'b0, cout8}, 0);
    chk("abort_ovf", {31'b0, ovf8}, 0);
    @(negedge clk);
    rst = 1'b0;
    prev_res8 = 0;
    seen_done = 1'b0;
    repeat (10) begin
      @(posedge clk); #1;
      if (done8 || busy8) seen_done = 1'b1;
    end
    chk("abort_no_done", {31'b0, seen_done}, 0);
    do_op8(8'h80, 8'h01, 1'b1);

    for (int i = 0; i < 30; i++)
      do_op8(int'($urandom_range(255)), int'($urandom_range(255)), 1'($urandom_range(1)));

    for (int m = 0; m < 2; m++)
      for (int x = 0; x < 16; x++)
        for (int y = 0; y < 16; y++)
          do_op4(x, y, 1'(m));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
